// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line levels
// and a counter-width helper. The receiver imports the same package.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit (bit_end) and the cycle before it (near_end, used to register
// the done pulse so it lands on the final stop cycle).
module serial_tx_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic near_end
);

    localparam int unsigned     CW   = clog2_min1(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   PRE  = (CLKS_PER_BIT > 1) ? CW'(CLKS_PER_BIT - 2) : '0;

    logic [CW-1:0] cnt;

    assign bit_end  = (cnt == LAST);
    assign near_end = (CLKS_PER_BIT > 1) && (cnt == PRE);

    // Cycle counter: restart on clear, wrap to zero after the terminal count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// All outputs are registered; the done cycle also reports ready so a new
// frame can start with no idle gap after the stop bit.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW       = clog2_min1(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bit_idx;
    logic             accept;
    logic             timer_clear;
    logic             bit_end;
    logic             near_end;

    assign accept      = ready && load;
    assign timer_clear = accept || (state == IDLE);
    assign shifted     = shreg >> 1;

    serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_end (bit_end),
        .near_end(near_end)
    );

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sout    <= IDLE_LEVEL;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            done <= 1'b0;
            // Accept has priority in both IDLE and the final stop cycle,
            // which is what makes back-to-back frames seamless.
            if (accept) begin
                state   <= START;
                shreg   <= din;
                bit_idx <= '0;
                sout    <= START_BIT;
                ready   <= 1'b0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        sout  <= IDLE_LEVEL;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            sout    <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shreg <= shifted;
                            if (bit_idx == LAST_BIT) begin
                                state <= STOP;
                                sout  <= STOP_BIT;
                                // A one-cycle stop bit is its own final cycle.
                                if (CLKS_PER_BIT == 1) begin
                                    done  <= 1'b1;
                                    ready <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                                sout    <= shifted[0];
                            end
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state <= IDLE;
                            sout  <= IDLE_LEVEL;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else if (near_end) begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sout  <= IDLE_LEVEL;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_serial_tx;

    logic       clk;
    logic       reset;
    logic       load,  load1;
    logic [7:0] din,   din1;
    logic       ready, sout, busy, done;
    logic       ready1, sout1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .load(load), .din(din),
        .ready(ready), .sout(sout), .busy(busy), .done(done)
    );

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(reset), .load(load1), .din(din1),
        .ready(ready1), .sout(sout1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level in cycle i (1-based) after the accepting edge.
    function automatic logic exp_bit(input logic [7:0] data, input int i, input int cpb);
        int b;
        b = (i - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " sout"},  sout,  1);
        check({tag, " ready"}, ready, 1);
        check({tag, " busy"},  busy,  0);
        check({tag, " done"},  done,  0);
    endtask

    // One 40-cycle frame on dut. pulse_at injects a load of 8'h3C while busy;
    // chain keeps load high and switches din to next_data for the next frame.
    task automatic tx_frame(input logic [7:0] data, input int pulse_at,
                            input bit chain, input logic [7:0] next_data);
        int dones;
        dones = 0;
        load  = 1'b1;
        din   = data;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                if (chain) din = next_data;
                else       load = 1'b0;
            end
            check($sformatf("sout %02h c%0d", data, i),  sout,  exp_bit(data, i, 4));
            check($sformatf("busy %02h c%0d", data, i),  busy,  1);
            check($sformatf("ready %02h c%0d", data, i), ready, (i == 40));
            check($sformatf("done %02h c%0d", data, i),  done,  (i == 40));
            if (done) dones++;
            if (i == pulse_at) begin
                load = 1'b1;
                din  = 8'h3C;
            end
            if (i == pulse_at + 1) load = 1'b0;
        end
        check($sformatf("done count %02h", data), dones, 1);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b1; din  = 8'hFF;
        load1 = 1'b1; din1 = 8'hFF;

        // Reset overrides load
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("reset c%0d", i));
            check($sformatf("reset1 sout c%0d", i),  sout1,  1);
            check($sformatf("reset1 ready c%0d", i), ready1, 1);
            check($sformatf("reset1 busy c%0d", i),  busy1,  0);
            check($sformatf("reset1 done c%0d", i),  done1,  0);
        end
        reset = 1'b0; load = 1'b0; load1 = 1'b0;
        @(posedge clk); #1;
        check_idle("post reset");

        // Single frame with an ignored load while busy
        tx_frame(8'hA5, 10, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("after A5 c%0d", i));
        end

        // Back-to-back frames, no idle gap
        tx_frame(8'h01, -1, 1'b1, 8'hFE);
        tx_frame(8'hFE, -1, 1'b0, 8'h00);
        @(posedge clk); #1;
        check_idle("after FE");

        // Reset in cycle 15 of a frame
        load = 1'b1; din = 8'h5A;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk); #1;
            if (i == 1) load = 1'b0;
            check($sformatf("sout 5A c%0d", i), sout, exp_bit(8'h5A, i, 4));
            check($sformatf("done 5A c%0d", i), done, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("mid reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("after mid reset c%0d", i));
        end
        tx_frame(8'hC3, -1, 1'b0, 8'h00);

        // One clock per bit
        load1 = 1'b1; din1 = 8'h80;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) load1 = 1'b0;
            check($sformatf("cpb1 sout c%0d", i),  sout1,  exp_bit(8'h80, i, 1));
            check($sformatf("cpb1 busy c%0d", i),  busy1,  1);
            check($sformatf("cpb1 ready c%0d", i), ready1, (i == 10));
            check($sformatf("cpb1 done c%0d", i),  done1,  (i == 10));
        end
        @(posedge clk); #1;
        check("cpb1 idle sout",  sout1,  1);
        check("cpb1 idle ready", ready1, 1);
        check("cpb1 idle busy",  busy1,  0);
        check("cpb1 idle done",  done1,  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
